// File: rtl/doodle_physics_core_if.sv
// Signal bundle between the game controller side and the per-frame physics core.
// The master drives the frame strobe and player/collision inputs; the slave returns sprite state.
interface doodle_physics_core_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic                  frame_tick;
    logic                  start;
    logic [7:0]            keycode;
    logic                  land_hit;
    logic                  boost;
    logic [X_W-1:0]        BallX;
    logic [Y_W-1:0]        BallY;
    logic [9:0]            BallS;
    logic signed [Y_W:0]   vel_y;
    logic [1:0]            state;
    logic [Y_W-1:0]        scroll_dy;
    logic                  game_over;

    modport master (
        output frame_tick, start, keycode, land_hit, boost,
        input  BallX, BallY, BallS, vel_y, state, scroll_dy, game_over
    );

    modport slave (
        input  frame_tick, start, keycode, land_hit, boost,
        output BallX, BallY, BallS, vel_y, state, scroll_dy, game_over
    );
endinterface

// File: rtl/doodle_physics_core.sv
// Per-frame motion engine for the jumping character: gravity, bounce, wrap, scroll and death.
// Every register advances only on frame_tick; all outputs come straight from registers.
module doodle_physics_core #(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_CENTER    = 320,
    parameter int Y_CENTER    = 240,
    parameter int SIZE        = 4,
    parameter int X_SPEED     = 2,
    parameter int JUMP_VEL    = 12,
    parameter int BOOST_VEL   = 20,
    parameter int GRAVITY     = 1,
    parameter int GRAV_DIV    = 2,
    parameter int VMAX_FALL   = 8,
    parameter int SCROLL_LINE = 160
) (
    input  logic Clk,
    input  logic Reset,
    doodle_physics_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RISING = 2'd1, FALLING = 2'd2, DEAD = 2'd3} state_t;

    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic signed [Y_W+1:0] SCROLL_S  = (Y_W+2)'(SCROLL_LINE);
    localparam logic signed [Y_W+1:0] SIZE_S    = (Y_W+2)'(SIZE);
    localparam logic signed [Y_W+1:0] YMAX_S    = (Y_W+2)'(Y_MAX);
    localparam logic signed [Y_W+1:0] VMAX_S    = (Y_W+2)'(VMAX_FALL);
    localparam logic signed [Y_W+1:0] GRAV_S    = (Y_W+2)'(GRAVITY);
    localparam logic signed [Y_W:0]   VEL_JUMP  = (Y_W+1)'(-JUMP_VEL);
    localparam logic signed [Y_W:0]   VEL_BOOST = (Y_W+1)'(-BOOST_VEL);
    localparam logic signed [X_W+1:0] XMIN_S    = (X_W+2)'(X_MIN);
    localparam logic signed [X_W+1:0] XMAX_S    = (X_W+2)'(X_MAX);
    localparam logic signed [X_W+1:0] XSPD_S    = (X_W+2)'(X_SPEED);

    state_t                state_reg, state_next;
    logic [X_W-1:0]        x_reg, x_next;
    logic [Y_W-1:0]        y_reg, y_next;
    logic signed [Y_W:0]   vel_reg, vel_next;
    logic [Y_W-1:0]        scroll_reg, scroll_next;
    logic [GW-1:0]         gcnt_reg, gcnt_next;
    logic                  go_reg, go_next;

    // Shared motion terms, always computed from the pre-tick register values
    logic signed [Y_W+1:0] y_sum, vel_grav;
    logic signed [Y_W:0]   vel_after;
    logic [GW-1:0]         gcnt_after;
    logic                  grav_step, move_r, move_l, land_now, die_now;
    logic signed [X_W+1:0] x_sum;
    logic [X_W-1:0]        x_wrap;

    assign y_sum      = $signed({2'b00, y_reg}) + $signed({vel_reg[Y_W], vel_reg});
    assign grav_step  = (gcnt_reg == GW'(GRAV_DIV - 1));
    assign vel_grav   = $signed({vel_reg[Y_W], vel_reg}) + GRAV_S;
    assign vel_after  = !grav_step ? vel_reg :
                        (vel_grav > VMAX_S) ? (Y_W+1)'(VMAX_S) : (Y_W+1)'(vel_grav);
    assign gcnt_after = grav_step ? '0 : gcnt_reg + GW'(1);

    assign move_r = (bus.keycode == 8'd7) || (bus.keycode == 8'd79);
    assign move_l = (bus.keycode == 8'd4) || (bus.keycode == 8'd80);
    assign x_sum  = $signed({2'b00, x_reg}) + (move_r ? XSPD_S : move_l ? -XSPD_S : '0);

    // Wrap carries the overshoot onto the opposite edge so speed is preserved
    always_comb begin
        x_wrap = x_sum[X_W-1:0];
        if (x_sum > XMAX_S)
            x_wrap = X_W'(XMIN_S + (x_sum - XMAX_S - 1));
        else if (x_sum < XMIN_S)
            x_wrap = X_W'(XMAX_S - (XMIN_S - x_sum - 1));
    end

    assign land_now = (state_reg == FALLING) && bus.land_hit;
    assign die_now  = (state_reg == FALLING) && !bus.land_hit && ((y_sum + SIZE_S) > YMAX_S);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            x_reg      <= X_W'(X_CENTER);
            y_reg      <= Y_W'(Y_CENTER);
            vel_reg    <= '0;
            scroll_reg <= '0;
            gcnt_reg   <= '0;
            go_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            vel_reg    <= vel_next;
            scroll_reg <= scroll_next;
            gcnt_reg   <= gcnt_next;
            go_reg     <= go_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.frame_tick) begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = RISING;
                RISING:  state_next = (vel_after < 0) ? RISING : FALLING;
                FALLING: begin
                    if (land_now)      state_next = RISING;
                    else if (die_now)  state_next = DEAD;
                    else               state_next = (vel_after < 0) ? RISING : FALLING;
                end
                default: if (bus.start) state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        x_next      = x_reg;
        y_next      = y_reg;
        vel_next    = vel_reg;
        scroll_next = scroll_reg;
        gcnt_next   = gcnt_reg;
        go_next     = go_reg;
        if (bus.frame_tick) begin
            scroll_next = '0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        vel_next  = VEL_JUMP;
                        gcnt_next = '0;
                    end
                end
                RISING: begin
                    x_next    = x_wrap;
                    vel_next  = vel_after;
                    gcnt_next = gcnt_after;
                    // Clamp at the scroll line and hand the overshoot to the world scroller
                    if (y_sum < SCROLL_S) begin
                        y_next      = Y_W'(SCROLL_S);
                        scroll_next = Y_W'(SCROLL_S - y_sum);
                    end else begin
                        y_next = Y_W'(y_sum);
                    end
                end
                FALLING: begin
                    x_next = x_wrap;
                    if (land_now) begin
                        vel_next  = bus.boost ? VEL_BOOST : VEL_JUMP;
                        gcnt_next = '0;
                    end else if (die_now) begin
                        y_next    = Y_W'(Y_MAX - SIZE);
                        vel_next  = '0;
                        gcnt_next = '0;
                        go_next   = 1'b1;
                    end else begin
                        y_next    = Y_W'(y_sum);
                        vel_next  = vel_after;
                        gcnt_next = gcnt_after;
                    end
                end
                default: begin
                    if (bus.start) begin
                        x_next    = X_W'(X_CENTER);
                        y_next    = Y_W'(Y_CENTER);
                        vel_next  = '0;
                        gcnt_next = '0;
                        go_next   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.BallX     = x_reg;
        bus.BallY     = y_reg;
        bus.BallS     = 10'(SIZE);
        bus.vel_y     = vel_reg;
        bus.state     = state_reg;
        bus.scroll_dy = scroll_reg;
        bus.game_over = go_reg;
    end
endmodule
